systolic_drain_unit: RTL and testbench
======================================

// Module: systolic_drain_unit
// PURPOSE
// - Return path of the 4x4 systolic array. Waits for the matmul-complete indication, snapshots
//   the 16 PE accumulators, then narrows each one to DATA_WIDTH with signed saturation.
// - Writes results back to the warp register file as two 8-lane beats using a valid/ready
//   handshake. Finally pulses a clear to the PE accumulators.
// - Sits between the PE array (accumulator outputs) and the thread register-file write port.
// PARAMETERS
// - DATA_WIDTH  16  width of one register-file lane (signed).
// - ACC_WIDTH   32  width of one PE accumulator (signed); must be >= DATA_WIDTH.
// - SATURATE    1   1: clamp to the signed DATA_WIDTH range; 0: truncate to the low DATA_WIDTH bits.
// PORTS
// - clk          in   1                   single clock; all logic on posedge.
// - reset_n      in   1                   asynchronous, active-low reset.
// - matmul_done  in   1                   level from push side; held high once the array has finished.
// - pause        in   1                   scheduler stall; freezes the FSM and masks wb_valid.
// - pe_acc       in   ACC_WIDTH x [15:0]  accumulator of PE[r][c] at index r*4+c.
// - wb_valid     out  1                   write-back beat is valid.
// - wb_ready     in   1                   register file accepts the beat.
// - wb_beat      out  1                   0 = rows 0-1, 1 = rows 2-3.
// - wb_data      out  DATA_WIDTH x [7:0]  lane i = C[2*wb_beat + i/4][i%4].
// - wb_sat       out  8                   per-lane flag: this lane was clamped.
// - acc_clear    out  1                   one-cycle pulse that zeroes the PE accumulators.
// - drain_busy   out  1                   high in every state except IDLE.
// - drain_done   out  1                   one-cycle pulse when the drain completes.
// BEHAVIOUR
// - Reset (async, reset_n=0):
//   - State = IDLE; snapshot registers = 0; done_q = 0.
//   - All outputs = 0 (wb_data = 0, wb_sat = 0).
//   - Asserting reset mid-drain abandons the drain; no partial completion pulse is produced.
// - Start condition:
//   - Start = matmul_done & ~done_q, where done_q is matmul_done registered on every clock.
//   - A rising edge seen while not in IDLE is ignored.
//   - A level that stays high does not restart the drain.
// - States: IDLE -> CAPTURE -> WB0 -> WB1 -> CLEAR -> DONE -> IDLE.
//   - IDLE: go to CAPTURE on start.
//   - CAPTURE: register all 16 narrowed values plus their saturation flags; go to WB0.
//   - WB0 / WB1: wb_valid = ~pause. Advance on the clock edge where wb_valid & wb_ready.
//     wb_data, wb_sat and wb_beat hold stable until that edge.
//   - CLEAR: acc_clear = 1 for exactly one cycle; go to DONE.
//   - DONE: drain_done = 1 for one cycle; go to IDLE.
// - pause:
//   - While pause = 1, the state holds and wb_valid = 0.
//   - acc_clear and drain_done are suppressed and deferred to the first un-paused cycle in
//     CLEAR / DONE. Each still pulses exactly once.
//   - pause has no effect in IDLE: a start edge is still detected and latched.
// - Latency: if matmul_done first rises in cycle N, wb_valid rises in cycle N+2.
//   With wb_ready tied high and pause low:
//   - beat0 in N+2, beat1 in N+3;
//   - acc_clear in N+4;
//   - drain_done in N+5;
//   - drain_busy high from N+1 through N+5.
// - Narrowing when SATURATE=1:
//   - acc > 2^(DATA_WIDTH-1)-1 becomes 0x7FFF and sets sat.
//   - acc < -2^(DATA_WIDTH-1) becomes 0x8000 and sets sat.
//   - Otherwise the low DATA_WIDTH bits are passed and sat = 0.
// - Narrowing when SATURATE=0: take the low bits; sat is always 0.
// - Snapshot: taken once, in CAPTURE only. Later changes on pe_acc do not affect beats in flight.
// - Outputs when not in WB0/WB1: wb_data and wb_sat read 0 and wb_beat reads 0.
// STRUCTURE
// - Shared package tc_pkg:
//   - drain_state_t enum {IDLE, CAPTURE, WB0, WB1, CLEAR, DONE};
//   - ARRAY_DIM = 4; WARP_SIZE = 8.
// - Sub-module sat_narrow #(ACC_WIDTH, DATA_WIDTH, SATURATE):
//   - purely combinational, input acc, outputs val and sat;
//   - instantiated 16 times, once per PE, feeding the CAPTURE registers.
// - Top level holds the FSM, edge detector, 16-entry snapshot and beat mux.
// TESTING
// - Basic drain:
//   - Stimulus: pe_acc[k] = k; matmul_done rises in cycle 0; wb_ready = 1.
//   - Response: wb_valid in cycles 2-3; beat0 lanes = 0..7, beat1 lanes = 8..15; wb_sat = 0;
//     acc_clear in cycle 4; drain_done in cycle 5.
// - Saturation:
//   - Stimulus: pe_acc[0] = 40000, pe_acc[1] = -40000, pe_acc[2] = 32767, pe_acc[3] = -32768.
//   - Response: beat0 lanes 0-3 = 0x7FFF, 0x8000, 0x7FFF, 0x8000; wb_sat[3:0] = 4'b0011.
// - Backpressure:
//   - Stimulus: wb_ready low for 5 cycles during WB0, and pe_acc changed during that time.
//   - Response: wb_valid stays high; wb_data stays stable and equal to the snapshot values;
//     beat1 follows one cycle after wb_ready goes high.
// - Pause:
//   - Stimulus: pause high for 3 cycles in WB1, and again in CLEAR.
//   - Response: wb_valid = 0 while paused; the beat is not lost; exactly one acc_clear and
//     one drain_done pulse.
// - Restart rules:
//   - Stimulus: matmul_done held high for 20 cycles, then low, then high again.
//   - Response: exactly two drains; a second rise while busy is ignored.
// - Reset mid-drain:
//   - Stimulus: reset_n = 0 in WB0.
//   - Response: all outputs are 0 immediately; IDLE after release; no drain_done pulse.

Source files
------------

// File: rtl/tc_pkg.sv
// Shared types and constants for the 4x4 tensor-core systolic array and its
// register-file return path.
package tc_pkg;

   localparam int ARRAY_DIM = 4;
   localparam int WARP_SIZE = 8;
   localparam int NUM_PE    = ARRAY_DIM * ARRAY_DIM;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CAPTURE = 3'd1,
      WB0     = 3'd2,
      WB1     = 3'd3,
      CLEAR   = 3'd4,
      DONE    = 3'd5
   } drain_state_t;

endpackage

// File: rtl/systolic_drain_unit_if.sv
// Register-file write-back channel: one 8-lane beat per valid/ready transfer,
// with per-lane saturation flags and a beat index selecting the row pair.
interface systolic_drain_unit_if
   import tc_pkg::*;
#(
   parameter int DATA_WIDTH = 16
) ();

   logic                                  wb_valid;
   logic                                  wb_ready;
   logic                                  wb_beat;
   logic [WARP_SIZE-1:0][DATA_WIDTH-1:0]  wb_data;
   logic [WARP_SIZE-1:0]                  wb_sat;

   modport master (
      output wb_valid,
      output wb_beat,
      output wb_data,
      output wb_sat,
      input  wb_ready
   );

   modport slave (
      input  wb_valid,
      input  wb_beat,
      input  wb_data,
      input  wb_sat,
      output wb_ready
   );

endinterface

// File: rtl/sat_narrow.sv
// Narrows one signed accumulator to DATA_WIDTH, either clamping to the signed
// range (flagging the clamp) or simply keeping the low bits.
module sat_narrow #(
   parameter int ACC_WIDTH  = 32,
   parameter int DATA_WIDTH = 16,
   parameter bit SATURATE   = 1'b1
) (
   input  logic [ACC_WIDTH-1:0]  acc,
   output logic [DATA_WIDTH-1:0] val,
   output logic                  sat
);

   // The value fits iff every bit from the sign bit down to the narrow sign bit agrees.
   logic [ACC_WIDTH-DATA_WIDTH:0] upper;
   logic                          overflow;

   assign upper    = acc[ACC_WIDTH-1:DATA_WIDTH-1];
   assign overflow = SATURATE && !((&upper) || !(|upper));

   // NOTE: combinational blocks use blocking '=' and give every output a default
   // first, so no path through the block can leave a value held (no latch).
   always_comb begin
      val = acc[DATA_WIDTH-1:0];
      sat = overflow;
      if (overflow) begin
         val = acc[ACC_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                : {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end
   end

endmodule

// File: rtl/systolic_drain_unit.sv
// Drains the 16 PE accumulators after a matmul: snapshot + narrow, write back as
// two 8-lane beats, then pulse an accumulator clear and a completion strobe.
module systolic_drain_unit
   import tc_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ACC_WIDTH  = 32,
   parameter bit SATURATE   = 1'b1
) (
   input  logic                               clk,
   input  logic                               reset_n,
   input  logic                               matmul_done,
   input  logic                               pause,
   input  logic [NUM_PE-1:0][ACC_WIDTH-1:0]   pe_acc,
   systolic_drain_unit_if.master              wb,
   output logic                               acc_clear,
   output logic                               drain_busy,
   output logic                               drain_done
);

   drain_state_t                          state_q, state_d;
   logic                                  done_q, done_d;
   logic [NUM_PE-1:0][DATA_WIDTH-1:0]     snap_val_q, snap_val_d;
   logic [NUM_PE-1:0]                     snap_sat_q, snap_sat_d;

   logic [NUM_PE-1:0][DATA_WIDTH-1:0]     narrow_val;
   logic [NUM_PE-1:0]                     narrow_sat;

   logic                                  start;
   logic                                  in_wb;
   logic                                  beat_sel;
   logic                                  valid;
   logic [WARP_SIZE-1:0][DATA_WIDTH-1:0]  data_mux;
   logic [WARP_SIZE-1:0]                  sat_mux;

   for (genvar k = 0; k < NUM_PE; k++) begin : g_narrow
      sat_narrow #(
         .ACC_WIDTH  (ACC_WIDTH),
         .DATA_WIDTH (DATA_WIDTH),
         .SATURATE   (SATURATE)
      ) u_sat_narrow (
         .acc (pe_acc[k]),
         .val (narrow_val[k]),
         .sat (narrow_sat[k])
      );
   end

   assign start    = matmul_done & ~done_q;
   assign in_wb    = (state_q == WB0) || (state_q == WB1);
   assign beat_sel = (state_q == WB1);
   assign valid    = in_wb & ~pause;

   always_comb begin
      state_d    = state_q;
      done_d     = matmul_done;
      snap_val_d = snap_val_q;
      snap_sat_d = snap_sat_q;
      // pause freezes every state except IDLE, so start edges are never lost.
      unique case (state_q)
         IDLE:    if (start) state_d = CAPTURE;
         CAPTURE: if (!pause) begin
            snap_val_d = narrow_val;
            snap_sat_d = narrow_sat;
            state_d    = WB0;
         end
         WB0:     if (valid && wb.wb_ready) state_d = WB1;
         WB1:     if (valid && wb.wb_ready) state_d = CLEAR;
         CLEAR:   if (!pause) state_d = DONE;
         DONE:    if (!pause) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Lane i of beat b is PE index b*WARP_SIZE + i; outside write-back everything reads 0.
   always_comb begin
      data_mux = '0;
      sat_mux  = '0;
      if (in_wb) begin
         for (int i = 0; i < WARP_SIZE; i++) begin
            if (beat_sel) begin
               data_mux[i] = snap_val_q[WARP_SIZE+i];
               sat_mux[i]  = snap_sat_q[WARP_SIZE+i];
            end else begin
               data_mux[i] = snap_val_q[i];
               sat_mux[i]  = snap_sat_q[i];
            end
         end
      end
   end

   assign wb.wb_valid = valid;
   assign wb.wb_beat  = beat_sel;
   assign wb.wb_data  = data_mux;
   assign wb.wb_sat   = sat_mux;
   assign acc_clear   = (state_q == CLEAR) & ~pause;
   assign drain_done  = (state_q == DONE) & ~pause;
   assign drain_busy  = (state_q != IDLE);

   // NOTE: sequential state uses non-blocking '<=' so every flop samples the
   // pre-edge values; the snapshot array is reset too, so read-back after reset is a
   // defined zero rather than X.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         done_q     <= 1'b0;
         snap_val_q <= '0;
         snap_sat_q <= '0;
      end else begin
         state_q    <= state_d;
         done_q     <= done_d;
         snap_val_q <= snap_val_d;
         snap_sat_q <= snap_sat_d;
      end
   end

endmodule

// File: tb/tb_systolic_drain_unit.sv
// Directed bench for systolic_drain_unit: latency, saturation, backpressure,
// pause, restart rules and reset mid-drain.
module tb_systolic_drain_unit;
   import tc_pkg::*;

   localparam int DW = 16;
   localparam int AW = 32;

   logic                        clk;
   logic                        reset_n;
   logic                        matmul_done;
   logic                        pause;
   logic [NUM_PE-1:0][AW-1:0]   pe_acc;
   logic                        acc_clear;
   logic                        drain_busy;
   logic                        drain_done;

   int n_cmp = 0;
   int n_err = 0;
   int n_clr = 0;
   int n_done = 0;
   int clr0, dn0, cyc;
   logic [127:0] exp_beat;

   systolic_drain_unit_if #(.DATA_WIDTH(DW)) wb_if ();

   systolic_drain_unit #(
      .DATA_WIDTH (DW),
      .ACC_WIDTH  (AW),
      .SATURATE   (1'b1)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .matmul_done (matmul_done),
      .pause       (pause),
      .pe_acc      (pe_acc),
      .wb          (wb_if.master),
      .acc_clear   (acc_clear),
      .drain_busy  (drain_busy),
      .drain_done  (drain_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse counters sample the value held during the cycle that just ended.
   always @(posedge clk) begin
      if (acc_clear)  n_clr  <= n_clr + 1;
      if (drain_done) n_done <= n_done + 1;
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   function automatic logic [127:0] lanes(input int base);
      logic [127:0] r;
      for (int i = 0; i < WARP_SIZE; i++) r[i*DW +: DW] = DW'(base + i);
      return r;
   endfunction

   task automatic load_ramp(input int base);
      for (int k = 0; k < NUM_PE; k++) pe_acc[k] = AW'(base + k);
   endtask

   initial begin
      reset_n = 1'b0; matmul_done = 1'b0; pause = 1'b0; wb_if.wb_ready = 1'b1;
      load_ramp(0);
      #2;
      check("rst_valid", 128'(wb_if.wb_valid), 128'd0);
      check("rst_busy",  128'(drain_busy),     128'd0);
      check("rst_data",  wb_if.wb_data,        128'd0);
      check("rst_sat",   128'(wb_if.wb_sat),   128'd0);
      adv(); adv();
      reset_n = 1'b1;
      adv();

      // Basic drain: cycle 0 is the first cycle with matmul_done high
      adv(); matmul_done = 1'b1; sample();
      check("basic_c0_busy",  128'(drain_busy),     128'd0);
      check("basic_c0_valid", 128'(wb_if.wb_valid), 128'd0);
      adv(); sample();
      check("basic_c1_busy",  128'(drain_busy),     128'd1);
      check("basic_c1_valid", 128'(wb_if.wb_valid), 128'd0);
      adv(); sample();
      check("basic_c2_valid", 128'(wb_if.wb_valid), 128'd1);
      check("basic_c2_beat",  128'(wb_if.wb_beat),  128'd0);
      check("basic_c2_data",  wb_if.wb_data,        lanes(0));
      check("basic_c2_sat",   128'(wb_if.wb_sat),   128'd0);
      adv(); sample();
      check("basic_c3_valid", 128'(wb_if.wb_valid), 128'd1);
      check("basic_c3_beat",  128'(wb_if.wb_beat),  128'd1);
      check("basic_c3_data",  wb_if.wb_data,        lanes(8));
      adv(); sample();
      check("basic_c4_clear", 128'(acc_clear),      128'd1);
      check("basic_c4_valid", 128'(wb_if.wb_valid), 128'd0);
      check("basic_c4_data",  wb_if.wb_data,        128'd0);
      check("basic_c4_beat",  128'(wb_if.wb_beat),  128'd0);
      adv(); sample();
      check("basic_c5_done",  128'(drain_done),     128'd1);
      check("basic_c5_clear", 128'(acc_clear),      128'd0);
      check("basic_c5_busy",  128'(drain_busy),     128'd1);
      adv(); sample();
      check("basic_c6_busy",  128'(drain_busy),     128'd0);
      check("basic_c6_done",  128'(drain_done),     128'd0);
      adv(); matmul_done = 1'b0;
      adv();

      // Saturation
      load_ramp(0);
      pe_acc[0] = AW'(40000); pe_acc[1] = AW'(-40000);
      pe_acc[2] = AW'(32767); pe_acc[3] = AW'(-32768);
      adv(); matmul_done = 1'b1;
      adv(); adv(); sample();
      exp_beat = lanes(0);
      exp_beat[15:0]  = 16'h7FFF; exp_beat[31:16] = 16'h8000;
      exp_beat[47:32] = 16'h7FFF; exp_beat[63:48] = 16'h8000;
      check("sat_data", wb_if.wb_data,      exp_beat);
      check("sat_flag", 128'(wb_if.wb_sat), 128'h03);
      adv(); sample();
      check("sat_beat1_data", wb_if.wb_data,      lanes(8));
      check("sat_beat1_flag", 128'(wb_if.wb_sat), 128'h00);
      adv(); adv(); adv(); matmul_done = 1'b0;
      adv();

      // Backpressure: ready low for 5 cycles in WB0 while pe_acc moves underneath
      load_ramp(100);
      wb_if.wb_ready = 1'b0;
      adv(); matmul_done = 1'b1;
      adv();
      for (int j = 0; j < 5; j++) begin
         adv();
         if (j == 1) load_ramp(16'h5000);
         sample();
         check("bp_valid", 128'(wb_if.wb_valid), 128'd1);
         check("bp_beat",  128'(wb_if.wb_beat),  128'd0);
         check("bp_data",  wb_if.wb_data,        lanes(100));
      end
      adv(); wb_if.wb_ready = 1'b1; sample();
      check("bp_accept_beat", 128'(wb_if.wb_beat), 128'd0);
      adv(); sample();
      check("bp_beat1_beat",  128'(wb_if.wb_beat), 128'd1);
      check("bp_beat1_data",  wb_if.wb_data,       lanes(108));
      adv(); adv(); adv(); matmul_done = 1'b0;
      adv();

      // Pause in WB1 and again in CLEAR
      load_ramp(0);
      clr0 = n_clr; dn0 = n_done;
      adv(); matmul_done = 1'b1;
      adv(); adv();
      adv(); pause = 1'b1; sample();
      for (int j = 0; j < 3; j++) begin
         check("pause_wb1_valid", 128'(wb_if.wb_valid), 128'd0);
         check("pause_wb1_beat",  128'(wb_if.wb_beat),  128'd1);
         if (j < 2) begin adv(); sample(); end
      end
      adv(); pause = 1'b0; sample();
      check("pause_wb1_resume_valid", 128'(wb_if.wb_valid), 128'd1);
      check("pause_wb1_resume_data",  wb_if.wb_data,        lanes(8));
      adv(); pause = 1'b1; sample();
      for (int j = 0; j < 3; j++) begin
         check("pause_clear_masked", 128'(acc_clear), 128'd0);
         if (j < 2) begin adv(); sample(); end
      end
      adv(); pause = 1'b0; sample();
      check("pause_clear_pulse", 128'(acc_clear),  128'd1);
      adv(); sample();
      check("pause_done_pulse",  128'(drain_done), 128'd1);
      adv(); sample();
      check("pause_idle",        128'(drain_busy), 128'd0);
      check("pause_clr_count",   128'(n_clr - clr0),  128'd1);
      check("pause_done_count",  128'(n_done - dn0),  128'd1);
      adv(); matmul_done = 1'b0;
      adv();

      // Restart rules: rise with pause high in IDLE, glitch while busy, long level
      dn0 = n_done;
      adv(); matmul_done = 1'b1; pause = 1'b1;
      adv(); pause = 1'b0; sample();
      check("rs_start_under_pause", 128'(drain_busy), 128'd1);
      adv();
      adv(); matmul_done = 1'b0;
      adv(); matmul_done = 1'b1;
      for (int j = 0; j < 16; j++) adv();
      sample();
      check("rs_level_no_restart", 128'(drain_busy),    128'd0);
      check("rs_one_drain",        128'(n_done - dn0),  128'd1);
      adv(); matmul_done = 1'b0;
      adv(); matmul_done = 1'b1;
      cyc = 0;
      sample();
      while (!drain_done && cyc < 20) begin
         adv(); sample(); cyc++;
      end
      check("rs_second_done_seen", 128'(drain_done), 128'd1);
      adv(); adv(); adv(); sample();
      check("rs_two_drains",       128'(n_done - dn0), 128'd2);
      check("rs_idle_after",       128'(drain_busy),   128'd0);

      // Reset mid-drain in WB0
      adv(); matmul_done = 1'b0;
      adv(); matmul_done = 1'b1; wb_if.wb_ready = 1'b0;
      adv(); adv(); sample();
      check("rm_in_wb0_valid", 128'(wb_if.wb_valid), 128'd1);
      dn0 = n_done;
      #1 reset_n = 1'b0;
      #1;
      check("rm_valid", 128'(wb_if.wb_valid), 128'd0);
      check("rm_busy",  128'(drain_busy),     128'd0);
      check("rm_data",  wb_if.wb_data,        128'd0);
      check("rm_beat",  128'(wb_if.wb_beat),  128'd0);
      check("rm_clear", 128'(acc_clear),      128'd0);
      check("rm_done",  128'(drain_done),     128'd0);
      matmul_done = 1'b0;
      adv(); adv(); reset_n = 1'b1; wb_if.wb_ready = 1'b1;
      for (int j = 0; j < 6; j++) adv();
      sample();
      check("rm_idle_after",   128'(drain_busy),  128'd0);
      check("rm_no_done",      128'(n_done - dn0), 128'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
